// File: rtl/conv_pkg.sv
// Shared constants and arithmetic helpers for the fixed-point convolution cores.
// Pure declarations: no logic, no latency.
package conv_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  localparam int CONV_K      = 3;
  localparam int CONV_DATA_W = 16;
  localparam int CONV_FRAC_W = 8;
  localparam int CONV_MAX_CH = 64;
  localparam int CONV_N      = CONV_K * CONV_K;
  localparam int CONV_T      = clog2(CONV_N);
  localparam int CONV_ACC_W  = 2 * CONV_DATA_W + clog2(CONV_N) + clog2(CONV_MAX_CH);
  localparam int CONV_LAT    = 4 + CONV_T;

  // Round half-up, then clip to data_w signed bits. Result packs the clipped
  // value in [data_w-1:0] and the saturation flag in bit data_w.
  function automatic logic [127:0] round_sat(input logic signed [127:0] x,
                                             input int frac_w, input int data_w);
    logic signed [127:0] r, hi, lo, o;
    logic sat;
    r   = (x + (128'sd1 <<< (frac_w - 1))) >>> frac_w;
    hi  = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    lo  = -(128'sd1 <<< (data_w - 1));
    sat = (r > hi) || (r < lo);
    o   = r;
    if (r > hi) o = hi;
    else if (r < lo) o = lo;
    o = o & ((128'sd1 <<< data_w) - 128'sd1);
    o[data_w] = sat;
    return o;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Pipelined signed adder tree, one register per level (latency clog2(N)).
// Fully streaming, no backpressure; a valid bit travels with the data.
module conv_adder_tree
  import conv_pkg::*;
#(
  parameter int N     = 9,
  parameter int IN_W  = 32,
  parameter int OUT_W = IN_W + clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_vld,
  input  logic [N*IN_W-1:0]       in_dat,
  output logic                    out_vld,
  output logic signed [OUT_W-1:0] out_dat
);

  localparam int T = clog2(N);

  logic signed [OUT_W-1:0] node  [0:T][0:N-1];
  logic signed [OUT_W-1:0] sum_q [1:T][0:N-1];
  logic signed [OUT_W-1:0] sum_d [1:T][0:N-1];
  logic [T:1] vld_q, vld_d;

  always_comb begin
    for (int i = 0; i < N; i++) node[0][i] = OUT_W'(signed'(in_dat[i*IN_W +: IN_W]));
    for (int l = 1; l <= T; l++)
      for (int i = 0; i < N; i++) node[l][i] = sum_q[l][i];
  end

  // Every level pairs across the full width; slots past the live count stay zero.
  always_comb begin
    for (int l = 1; l <= T; l++) begin
      for (int i = 0; i < N; i++) sum_d[l][i] = '0;
      for (int i = 0; 2 * i + 1 < N; i++) sum_d[l][i] = node[l-1][2*i] + node[l-1][2*i+1];
      if (N % 2 == 1) sum_d[l][N/2] = node[l-1][N-1];
    end
    vld_d[1] = in_vld;
    for (int l = 2; l <= T; l++) vld_d[l] = vld_q[l-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int l = 1; l <= T; l++)
        for (int i = 0; i < N; i++) sum_q[l][i] <= '0;
    end else begin
      vld_q <= vld_d;
      for (int l = 1; l <= T; l++)
        for (int i = 0; i < N; i++) sum_q[l][i] <= sum_d[l][i];
    end
  end

  assign out_dat = sum_q[T][0];
  assign out_vld = vld_q[T];

endmodule

// File: rtl/conv_core_kxk_fx.sv
// KxK fixed-point conv core: MAC tree, channel accumulate, bias/round/saturate; latency 4+clog2(K*K), no backpressure.
// Define CONV_RELU_EN to clamp negative results to zero after saturation.
module conv_core_kxk_fx
  import conv_pkg::*;
#(
  parameter int K      = 3,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int MAX_CH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        Valid_In,
  input  logic                        First_In,
  input  logic                        Last_In,
  input  logic [K*K*DATA_W-1:0]       Data_In,
  input  logic                        Kernel_Wr,
  input  logic [clog2(K*K+1)-1:0]     Kernel_Addr,
  input  logic [DATA_W-1:0]           Kernel_Data,
  input  logic                        Kernel_Swap,
  output logic [DATA_W-1:0]           Data_Out,
  output logic                        Valid_Out,
  output logic                        Sat_Out
);

  localparam int N      = K * K;
  localparam int T      = clog2(N);
  localparam int PROD_W = 2 * DATA_W;
  localparam int SUM_W  = PROD_W + T;
  localparam int ACC_W  = 2 * DATA_W + clog2(N) + clog2(MAX_CH);
  localparam int RES_W  = ACC_W + 1;
  localparam int RS_W   = DATA_W + 1;

  logic [DATA_W-1:0] shadow_q [0:N], shadow_d [0:N], active_q [0:N], active_d [0:N];
  logic s0_vld_q, s0_vld_d, s0_first_q, s0_first_d, s0_last_q, s0_last_d;
  logic [N*DATA_W-1:0] s0_dat_q, s0_dat_d;
  logic [DATA_W-1:0] s0_krn_q [0:N-1], s0_krn_d [0:N-1];
  logic [DATA_W-1:0] s0_bias_q, s0_bias_d;
  logic s1_vld_q, s1_vld_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [DATA_W-1:0] s1_bias_q, s1_bias_d;
  logic [N*PROD_W-1:0] prod_q, prod_d;
  logic [T:1] sb_first_q, sb_first_d, sb_last_q, sb_last_d;
  logic [DATA_W-1:0] sb_bias_q [1:T], sb_bias_d [1:T];
  logic tree_vld;
  logic signed [SUM_W-1:0] tree_sum;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic signed [RES_W-1:0] res_q, res_d;
  logic res_vld_q, res_vld_d;
  logic [RS_W-1:0] rs;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic vout_q, vout_d, sat_q, sat_d;

  // A swap sees the shadow as it stood before any same-cycle write.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (Kernel_Swap) active_d = shadow_q;
    if (Kernel_Wr && (int'(Kernel_Addr) <= N)) shadow_d[Kernel_Addr] = Kernel_Data;
  end

  always_comb begin
    logic signed [DATA_W-1:0] a_s, b_s;
    s0_vld_d   = Valid_In;
    s0_first_d = Valid_In & First_In;
    s0_last_d  = Valid_In & Last_In;
    s0_dat_d   = Data_In;
    for (int i = 0; i < N; i++) s0_krn_d[i] = active_q[i];
    s0_bias_d  = active_q[N];
    s1_vld_d   = s0_vld_q;
    s1_first_d = s0_first_q;
    s1_last_d  = s0_last_q;
    s1_bias_d  = s0_bias_q;
    prod_d     = '0;
    for (int i = 0; i < N; i++) begin
      a_s = s0_dat_q[i*DATA_W +: DATA_W];
      b_s = s0_krn_q[i];
      prod_d[i*PROD_W +: PROD_W] = PROD_W'(a_s) * PROD_W'(b_s);
    end
  end

  conv_adder_tree #(.N(N), .IN_W(PROD_W), .OUT_W(SUM_W)) u_tree (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (s1_vld_q),
    .in_dat  (prod_q),
    .out_vld (tree_vld),
    .out_dat (tree_sum)
  );

  // Framing and bias ride alongside the tree so they line up with its sum.
  always_comb begin
    sb_first_d[1] = s1_first_q;
    sb_last_d[1]  = s1_last_q;
    sb_bias_d[1]  = s1_bias_q;
    for (int l = 2; l <= T; l++) begin
      sb_first_d[l] = sb_first_q[l-1];
      sb_last_d[l]  = sb_last_q[l-1];
      sb_bias_d[l]  = sb_bias_q[l-1];
    end
  end

  always_comb begin
    acc_d     = acc_q;
    res_d     = res_q;
    res_vld_d = 1'b0;
    acc_sum   = (sb_first_q[T] ? '0 : acc_q) + ACC_W'(tree_sum);
    if (tree_vld) begin
      if (sb_last_q[T]) begin
        res_d     = RES_W'(acc_sum) + (RES_W'(signed'(sb_bias_q[T])) <<< FRAC_W);
        acc_d     = '0;
        res_vld_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  always_comb begin
    rs     = RS_W'(round_sat(128'(res_q), FRAC_W, DATA_W));
    dout_d = dout_q;
    sat_d  = sat_q;
    vout_d = res_vld_q;
    if (res_vld_q) begin
      dout_d = rs[DATA_W-1:0];
      sat_d  = rs[DATA_W];
`ifdef CONV_RELU_EN
      if (rs[DATA_W-1]) dout_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= N; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
      for (int i = 0; i < N; i++) s0_krn_q[i] <= '0;
      for (int l = 1; l <= T; l++) sb_bias_q[l] <= '0;
      {s0_vld_q, s0_first_q, s0_last_q, s1_vld_q, s1_first_q, s1_last_q} <= '0;
      s0_dat_q <= '0; s0_bias_q <= '0; s1_bias_q <= '0; prod_q <= '0;
      sb_first_q <= '0; sb_last_q <= '0;
      acc_q <= '0; res_q <= '0; res_vld_q <= 1'b0;
      dout_q <= '0; vout_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      s0_krn_q <= s0_krn_d;
      sb_bias_q <= sb_bias_d;
      {s0_vld_q, s0_first_q, s0_last_q} <= {s0_vld_d, s0_first_d, s0_last_d};
      {s1_vld_q, s1_first_q, s1_last_q} <= {s1_vld_d, s1_first_d, s1_last_d};
      s0_dat_q <= s0_dat_d; s0_bias_q <= s0_bias_d; s1_bias_q <= s1_bias_d; prod_q <= prod_d;
      sb_first_q <= sb_first_d; sb_last_q <= sb_last_d;
      acc_q <= acc_d; res_q <= res_d; res_vld_q <= res_vld_d;
      dout_q <= dout_d; vout_q <= vout_d; sat_q <= sat_d;
    end
  end

  assign Data_Out  = dout_q;
  assign Valid_Out = vout_q;
  assign Sat_Out   = sat_q;

endmodule

// File: tb/tb_conv_core_kxk_fx.sv
// Directed scoreboard bench for conv_core_kxk_fx at K=3, Q8.8, 64 channels.
module tb_conv_core_kxk_fx;
  import conv_pkg::*;

  localparam int N  = 9;
  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic Valid_In = 1'b0, First_In = 1'b0, Last_In = 1'b0;
  logic [N*DW-1:0] Data_In = '0;
  logic Kernel_Wr = 1'b0, Kernel_Swap = 1'b0;
  logic [AW-1:0] Kernel_Addr = '0;
  logic [DW-1:0] Kernel_Data = '0;
  logic [DW-1:0] Data_Out;
  logic Valid_Out, Sat_Out;

  always #5 clk = ~clk;

  conv_core_kxk_fx #(.K(3), .DATA_W(16), .FRAC_W(8), .MAX_CH(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .Valid_In    (Valid_In),
    .First_In    (First_In),
    .Last_In     (Last_In),
    .Data_In     (Data_In),
    .Kernel_Wr   (Kernel_Wr),
    .Kernel_Addr (Kernel_Addr),
    .Kernel_Data (Kernel_Data),
    .Kernel_Swap (Kernel_Swap),
    .Data_Out    (Data_Out),
    .Valid_Out   (Valid_Out),
    .Sat_Out     (Sat_Out)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] d; logic s; int c; } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = v;
    return d;
  endfunction

  task automatic drv(input logic v, input logic f, input logic l, input logic [N*DW-1:0] d,
                     input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] kd,
                     input logic sw, input logic [DW-1:0] ed, input logic es);
    Valid_In = v; First_In = f; Last_In = l; Data_In = d;
    Kernel_Wr = wr; Kernel_Addr = a; Kernel_Data = kd; Kernel_Swap = sw;
    if (v && l) sb.push_back('{d: ed, s: es, c: cyc + CONV_LAT});
    @(posedge clk); #1;
    Valid_In = 1'b0; First_In = 1'b0; Last_In = 1'b0; Kernel_Wr = 1'b0; Kernel_Swap = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic win(input logic [DW-1:0] v, input logic f, input logic l,
                     input logic [DW-1:0] ed, input logic es);
    drv(1'b1, f, l, fill(v), 1'b0, '0, '0, 1'b0, ed, es);
  endtask

  task automatic win_tap0(input logic [DW-1:0] v, input logic [DW-1:0] ed);
    logic [N*DW-1:0] d;
    d = '0;
    d[DW-1:0] = v;
    drv(1'b1, 1'b1, 1'b1, d, 1'b0, '0, '0, 1'b0, ed, 1'b0);
  endtask

  // ramp=1 loads taps 1.0..9.0, otherwise every tap gets kv; then swaps.
  task automatic load_swap(input bit ramp, input logic [DW-1:0] kv, input logic [DW-1:0] bias);
    for (int i = 0; i < N; i++)
      drv(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'(i), ramp ? DW'((i + 1) * 256) : kv, 1'b0, '0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'(N), bias, 1'b0, '0, 1'b0);
    drv(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, '0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (Valid_Out === 1'b1) begin
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_bad++;
          $error("FAIL unexpected_valid: Valid_Out=1 at cycle %0d, expected no output", cyc);
        end
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("data_out", 32'(Data_Out), 32'(e.d));
          chk("sat_out", 32'(Sat_Out), 32'(e.s));
          chk("latency_cycle", 32'(cyc), 32'(e.c));
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [DW-1:0] relu_neg, relu_sat;
`ifdef CONV_RELU_EN
    relu_neg = 16'h0000; relu_sat = 16'h0000;
`else
    relu_neg = 16'hF700; relu_sat = 16'h8000;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data", 32'(Data_Out), 32'h0);
    chk("reset_valid", 32'(Valid_Out), 32'h0);
    chk("reset_sat", 32'(Sat_Out), 32'h0);
    rst = 1'b0;

    // Single channel, then multi-channel framing variants.
    load_swap(1'b1, '0, 16'h0000);
    win(16'h0100, 1'b1, 1'b1, 16'h2D00, 1'b0);
    idle(10);
    win(16'h0080, 1'b1, 1'b0, '0, 1'b0);
    win(16'h0080, 1'b0, 1'b0, '0, 1'b0);
    win(16'h0080, 1'b0, 1'b1, 16'h4380, 1'b0);
    win(16'h0080, 1'b1, 1'b0, '0, 1'b0);
    idle(2);
    win(16'h0080, 1'b0, 1'b0, '0, 1'b0);
    idle(1);
    win(16'h0080, 1'b0, 1'b1, 16'h4380, 1'b0);
    win(16'h0080, 1'b0, 1'b1, 16'h1680, 1'b0);
    win(16'h0080, 1'b0, 1'b0, '0, 1'b0);
    win(16'h0080, 1'b0, 1'b1, 16'h2D00, 1'b0);
    win(16'h0100, 1'b1, 1'b0, '0, 1'b0);
    win(16'h0080, 1'b1, 1'b1, 16'h1680, 1'b0);
    idle(10);

    // Bias and half-up rounding.
    load_swap(1'b1, '0, 16'h0180);
    win(16'h0100, 1'b1, 1'b1, 16'h2E80, 1'b0);
    load_swap(1'b0, 16'h0080, 16'h0000);
    win_tap0(16'h0001, 16'h0001);
    win_tap0(16'hFFFF, 16'h0000);
    win_tap0(16'h0003, 16'h0002);
    win_tap0(16'hFFFD, 16'hFFFF);
    idle(10);

    // Saturation both directions, and negative result for ReLU.
    load_swap(1'b0, 16'h7FFF, 16'h0000);
    win(16'h7FFF, 1'b1, 1'b1, 16'h7FFF, 1'b1);
    load_swap(1'b0, 16'h8000, 16'h0000);
    win(16'h7FFF, 1'b1, 1'b1, relu_sat, 1'b1);
    load_swap(1'b0, 16'hFF00, 16'h0000);
    win(16'h0100, 1'b1, 1'b1, relu_neg, 1'b0);
    idle(10);

    // Shadow reload while streaming; swap between A and B with no bubble.
    load_swap(1'b1, '0, 16'h0000);
    for (int i = 0; i < N; i++)
      drv(1'b1, 1'b1, 1'b1, fill(16'h0100), 1'b1, AW'(i), 16'h0200, 1'b0, 16'h2D00, 1'b0);
    drv(1'b1, 1'b1, 1'b1, fill(16'h0100), 1'b1, AW'(12), 16'h7FFF, 1'b0, 16'h2D00, 1'b0);
    drv(1'b1, 1'b1, 1'b1, fill(16'h0100), 1'b1, AW'(N), 16'h0100, 1'b1, 16'h2D00, 1'b0);
    win(16'h0100, 1'b1, 1'b1, 16'h1200, 1'b0);
    drv(1'b1, 1'b1, 1'b1, fill(16'h0100), 1'b0, '0, '0, 1'b1, 16'h1200, 1'b0);
    win(16'h0100, 1'b1, 1'b1, 16'h1300, 1'b0);
    idle(10);

    // Reset three cycles after a Last_In: the in-flight result must vanish.
    win(16'h0100, 1'b1, 1'b1, 16'h1300, 1'b0);
    idle(2);
    rst = 1'b1;
    sb.delete();
    idle(2);
    rst = 1'b0;
    chk("midrst_data", 32'(Data_Out), 32'h0);
    chk("midrst_valid", 32'(Valid_Out), 32'h0);
    chk("midrst_sat", 32'(Sat_Out), 32'h0);
    idle(12);
    win(16'h0100, 1'b1, 1'b1, 16'h0000, 1'b0);
    drv(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, '0, 1'b0);
    win(16'h0100, 1'b1, 1'b1, 16'h0000, 1'b0);
    load_swap(1'b1, '0, 16'h0000);
    win(16'h0100, 1'b1, 1'b1, 16'h2D00, 1'b0);
    idle(12);

    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
